// File: rtl/dbus_rx_fifo_port_pkg.sv
// Shared register-map constants and helpers for the Dw-bus receive FIFO port.
package dbus_rx_fifo_port_pkg;

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_DATA   = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_sel_e;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_OVF_CLR = 1;
  localparam int CTRL_IE      = 2;

  localparam int ST_NEMPTY = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_IE     = 3;
  localparam int ST_CNT_LO = 8;

  typedef struct packed {
    logic flush;
    logic ovf_clr;
    logic ie_wr;
    logic ie_val;
  } ctrl_wr_t;

  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:4] == base[31:4];
  endfunction

endpackage

// File: rtl/dbus_rx_fifo_port_if.sv
// CPU data-bus (Dw*) responder signals grouped for the receive FIFO port.
interface dbus_rx_fifo_port_if;
  import dbus_rx_fifo_port_pkg::*;

  logic        DwReadEnable;
  logic        DwWriteEnable;
  logic [3:0]  DwByteEnable;
  logic [31:0] DwAddress;
  logic [31:0] DwWriteData;
  logic [31:0] DwReadData;
  logic        oSel;

  modport master (
    output DwReadEnable, DwWriteEnable, DwByteEnable, DwAddress, DwWriteData,
    input  DwReadData, oSel
  );

  modport slave (
    input  DwReadEnable, DwWriteEnable, DwByteEnable, DwAddress, DwWriteData,
    output DwReadData, oSel
  );
endinterface

// File: rtl/dbus_rx_fifo_port_sync_fifo.sv
// Synchronous FIFO with flush; push ignored when full, pop ignored when empty.
module dbus_sync_fifo
  import dbus_rx_fifo_port_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_head,
  output logic [CW-1:0]     o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; contents past reset/flush are never observed.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_tail] <= i_data;
  end

endmodule

// File: rtl/dbus_rx_fifo_port.sv
// Dw-bus memory-mapped receive FIFO: producer pushes bytes, CPU polls STATUS/DATA
// or takes an interrupt; DATA reads pop once per strobe assertion.
module dbus_rx_fifo_port
  import dbus_rx_fifo_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFF20_0100,
  parameter int          DEPTH     = 16,
  parameter int          DATA_W    = 8,
  localparam int         CW        = $clog2(DEPTH) + 1
) (
  input  logic              iCLK,
  input  logic              iRST,
  dbus_rx_fifo_port_if.slave bus,
  input  logic [DATA_W-1:0] iInData,
  input  logic              iInValid,
  output logic              oInReady,
  output logic              oIRQ
);

  logic              r_rd_q;
  logic              r_ovf;
  logic              r_ie;

  logic              w_sel;
  reg_sel_e          w_reg;
  logic              w_rd_data;
  logic              w_ctrl_wr;
  ctrl_wr_t          w_ctrl;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_head;
  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;
  logic [31:0]       w_status;
  logic              w_unused_bits;

  assign w_sel     = in_window(bus.DwAddress, BASE_ADDR);
  assign w_reg     = reg_sel_e'(bus.DwAddress[3:2]);
  assign w_rd_data = bus.DwReadEnable && w_sel && (w_reg == REG_DATA);
  assign w_ctrl_wr = bus.DwWriteEnable && w_sel && (w_reg == REG_CTRL) && bus.DwByteEnable[0];

  assign w_ctrl.flush   = w_ctrl_wr && bus.DwWriteData[CTRL_FLUSH];
  assign w_ctrl.ovf_clr = w_ctrl_wr && bus.DwWriteData[CTRL_OVF_CLR];
  assign w_ctrl.ie_wr   = w_ctrl_wr;
  assign w_ctrl.ie_val  = bus.DwWriteData[CTRL_IE];

  // Pop only on the rising edge of a DATA read; a concurrent write suppresses it.
  assign w_pop    = w_rd_data && !r_rd_q && !bus.DwWriteEnable && !w_empty;
  assign w_push   = iInValid && !w_full;
  assign oInReady = !w_full;
  assign oIRQ     = r_ie && !w_empty;

  dbus_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .i_clk   (iCLK),
    .i_rst   (iRST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_ctrl.flush),
    .i_data  (iInData),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_rd_q <= 1'b0;
      r_ovf  <= 1'b0;
      r_ie   <= 1'b0;
    end else begin
      r_rd_q <= w_rd_data;
      // Clear beats a same-cycle overflow.
      if (w_ctrl.ovf_clr)            r_ovf <= 1'b0;
      else if (iInValid && w_full)   r_ovf <= 1'b1;
      if (w_ctrl.ie_wr)              r_ie  <= w_ctrl.ie_val;
    end
  end

  always_comb begin
    w_status            = '0;
    w_status[ST_NEMPTY] = !w_empty;
    w_status[ST_FULL]   = w_full;
    w_status[ST_OVF]    = r_ovf;
    w_status[ST_IE]     = r_ie;
    w_status[ST_CNT_LO +: 8] = 8'(w_count);
  end

  always_comb begin
    bus.DwReadData = '0;
    if (w_sel) begin
      case (w_reg)
        REG_STATUS: bus.DwReadData = w_status;
        REG_DATA:   bus.DwReadData = w_empty ? 32'h0 : 32'(w_head);
        REG_CTRL:   bus.DwReadData = {29'b0, r_ie, 2'b00};
        default:    bus.DwReadData = '0;
      endcase
    end
  end

  assign bus.oSel = w_sel;

  assign w_unused_bits = ^{bus.DwAddress[1:0], bus.DwByteEnable[3:1], bus.DwWriteData[31:3]};

endmodule

// File: tb/tb_dbus_rx_fifo_port.sv
// Directed bench for dbus_rx_fifo_port: register map, pop edge logic, overflow, flush, IRQ, reset.
module tb_dbus_rx_fifo_port;
  import dbus_rx_fifo_port_pkg::*;

  localparam logic [31:0] BASE = 32'hFF20_0100;
  localparam logic [31:0] A_ST = BASE + 32'h0;
  localparam logic [31:0] A_DT = BASE + 32'h4;
  localparam logic [31:0] A_CT = BASE + 32'h8;
  localparam logic [31:0] A_RS = BASE + 32'hC;

  logic       iCLK = 1'b0;
  logic       iRST;
  logic [7:0] iInData;
  logic       iInValid;
  logic       oInReady;
  logic       oIRQ;

  int n_chk = 0;
  int n_err = 0;

  dbus_rx_fifo_port_if bus ();

  dbus_rx_fifo_port #(.BASE_ADDR(BASE), .DEPTH(16), .DATA_W(8)) dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .bus      (bus.slave),
    .iInData  (iInData),
    .iInValid (iInValid),
    .oInReady (oInReady),
    .oIRQ     (oIRQ)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    bus.DwAddress = a;
    #1 d = bus.DwReadData;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge iCLK);
    bus.DwReadEnable = 1'b1;
    bus.DwAddress    = a;
    #1 d = bus.DwReadData;
    @(negedge iCLK);
    bus.DwReadEnable = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v, input logic [3:0] be);
    @(negedge iCLK);
    bus.DwWriteEnable = 1'b1;
    bus.DwAddress     = a;
    bus.DwWriteData   = v;
    bus.DwByteEnable  = be;
    @(negedge iCLK);
    bus.DwWriteEnable = 1'b0;
  endtask

  task automatic push_burst(input int n, input logic [7:0] start);
    @(negedge iCLK);
    iInValid = 1'b1;
    for (int i = 0; i < n; i++) begin
      iInData = start + 8'(i);
      @(negedge iCLK);
    end
    iInValid = 1'b0;
  endtask

  initial begin
    #200000;
    n_chk++;
    n_err++;
    $display("FAIL timeout: got no end expected end");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    iRST = 1'b1;
    iInData = '0;
    iInValid = 1'b0;
    bus.DwReadEnable = 1'b0;
    bus.DwWriteEnable = 1'b0;
    bus.DwByteEnable = 4'h0;
    bus.DwAddress = '0;
    bus.DwWriteData = '0;
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;

    peek(A_ST, d);       chk("rst_status", d, 32'h0);
    chk("rst_ready", 32'(oInReady), 32'h1);
    chk("rst_irq", 32'(oIRQ), 32'h0);
    chk("rst_sel", 32'(bus.oSel), 32'h1);

    push_burst(3, 8'h41);
    peek(A_ST, d);       chk("st3", d, 32'h0000_0301);
    rd(A_DT, d);         chk("rd41", d, 32'h41);
    rd(A_DT, d);         chk("rd42", d, 32'h42);
    rd(A_DT, d);         chk("rd43", d, 32'h43);
    peek(A_ST, d);       chk("st_empty", d, 32'h0);

    push_burst(2, 8'h55);
    @(negedge iCLK);
    bus.DwReadEnable = 1'b1;
    bus.DwAddress = A_DT;
    #1 chk("hold0", bus.DwReadData, 32'h55);
    @(negedge iCLK);
    #1 chk("hold1", bus.DwReadData, 32'h56);
    @(negedge iCLK);
    #1 chk("hold2", bus.DwReadData, 32'h56);
    @(negedge iCLK);
    bus.DwReadEnable = 1'b0;
    peek(A_ST, d);       chk("hold_st", d, 32'h0000_0101);
    rd(A_DT, d);         chk("hold_drain", d, 32'h56);

    push_burst(16, 8'h10);
    peek(A_ST, d);       chk("st16", d, 32'h0000_1003);
    chk("full_ready", 32'(oInReady), 32'h0);
    push_burst(1, 8'h20);
    peek(A_ST, d);       chk("st17", d, 32'h0000_1007);

    @(negedge iCLK);
    bus.DwReadEnable = 1'b1;
    bus.DwAddress = A_DT;
    iInValid = 1'b1;
    iInData = 8'hAA;
    #1 chk("pp_data", bus.DwReadData, 32'h10);
    chk("pp_ready0", 32'(oInReady), 32'h0);
    @(negedge iCLK);
    bus.DwReadEnable = 1'b0;
    peek(A_ST, d);       chk("pp_st15", d, 32'h0000_0F05);
    chk("pp_ready1", 32'(oInReady), 32'h1);
    @(negedge iCLK);
    iInValid = 1'b0;
    peek(A_ST, d);       chk("pp_st16", d, 32'h0000_1007);

    wr(A_CT, 32'h3, 4'b0001);
    peek(A_ST, d);       chk("flush_st", d, 32'h0);

    push_burst(1, 8'h77);
    chk("irq_off", 32'(oIRQ), 32'h0);
    wr(A_CT, 32'h4, 4'b0001);
    chk("irq_on", 32'(oIRQ), 32'h1);
    peek(A_CT, d);       chk("ctrl_rd", d, 32'h4);
    peek(A_ST, d);       chk("ie_st", d, 32'h0000_0109);
    wr(A_CT, 32'h1, 4'b0010);
    peek(A_ST, d);       chk("be_ign", d, 32'h0000_0109);
    wr(A_DT, 32'h1, 4'b1111);
    peek(A_ST, d);       chk("data_wr_ign", d, 32'h0000_0109);
    wr(A_CT, 32'h1, 4'b0001);
    peek(A_ST, d);       chk("flush2_st", d, 32'h0);
    chk("irq_clr", 32'(oIRQ), 32'h0);

    push_burst(17, 8'h30);
    peek(A_ST, d);       chk("pre_rst_st", d, 32'h0000_1007);
    @(negedge iCLK);
    iRST = 1'b1;
    bus.DwReadEnable = 1'b1;
    bus.DwAddress = A_DT;
    @(negedge iCLK);
    iRST = 1'b0;
    bus.DwReadEnable = 1'b0;
    peek(A_ST, d);       chk("post_rst_st", d, 32'h0);
    chk("post_rst_ready", 32'(oInReady), 32'h1);
    rd(A_DT, d);         chk("rd_empty", d, 32'h0);
    peek(A_RS, d);       chk("rsvd_rd", d, 32'h0);
    peek(BASE + 32'h10, d); chk("out_win_data", d, 32'h0);
    chk("out_win_sel", 32'(bus.oSel), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
